// File: rtl/onebit_parallel_ctrl.sv
// onebit_parallel_ctrl: frame-aligned serial-to-parallel word controller with valid/ready output and sticky overflow (ONEBIT_MSB_FIRST_EN selects MSB-first capture)
module onebit_parallel_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sof,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             ovf,
  input  logic             clr_ovf
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_n;
  logic [WIDTH-1:0] sh_q, sh_n, ins, word_q;
  logic [CNT_W-1:0] cnt_q, cnt_n, pidx, pos;
  logic vld_q, ovf_q, fresh, take, done, load;
  // a sof bit starts a fresh word at position 0; otherwise the bit lands at the running count
  always_comb begin
    fresh = state_q == IDLE || sof;
    pidx = fresh ? '0 : cnt_q;
`ifdef ONEBIT_MSB_FIRST_EN
    pos = CNT_W'(WIDTH - 1) - pidx;
`else
    pos = pidx;
`endif
    ins = ((fresh ? '0 : sh_q) & ~(WIDTH'(1) << pos)) | (WIDTH'(bit_in) << pos);
    take = en && bit_vld && (state_q == SHIFT || sof);
    done = take && !sof && cnt_q == CNT_W'(WIDTH - 1);
    load = done && (!vld_q || word_rdy);
    state_n = !en ? IDLE : take ? SHIFT : state_q;
    cnt_n = !en ? '0 : !take ? cnt_q : sof ? CNT_W'(1) : done ? '0 : cnt_q + CNT_W'(1);
    sh_n = !en ? '0 : take ? ins : sh_q;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_n;
  // datapath, output register and sticky overflow (a drop outranks a clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sh_q <= sh_n;
      cnt_q <= cnt_n;
      word_q <= load ? ins : word_q;
      vld_q <= load | (vld_q & ~word_rdy);
      ovf_q <= (done & ~load) | (ovf_q & ~clr_ovf);
    end
  end
  assign word_out = word_q;
  assign word_vld = vld_q;
  assign busy = state_q == SHIFT;
  assign bit_cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_onebit_parallel_ctrl.sv
// tb_onebit_parallel_ctrl: table-driven plus directed-sequence check of onebit_parallel_ctrl (WIDTH=8)
module tb_onebit_parallel_ctrl;
  logic clk = 0, rst = 0, en = 0, sof = 0, bit_in = 0, bit_vld = 0, word_rdy = 0, clr_ovf = 0;
  logic [7:0] word_out;
  logic [3:0] bit_cnt;
  logic word_vld, busy, ovf;
  int errors = 0, checks = 0, pulses;
  typedef struct {
    logic en, sof, vld, b, rdy, clr;
    logic ev; logic [7:0] ew; logic eb; logic [3:0] ec; logic eo;
  } vec_t;
  vec_t tbl[$];
  onebit_parallel_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sof(sof), .bit_in(bit_in), .bit_vld(bit_vld),
    .word_out(word_out), .word_vld(word_vld), .word_rdy(word_rdy), .busy(busy),
    .bit_cnt(bit_cnt), .ovf(ovf), .clr_ovf(clr_ovf)
  );
  always #5 clk = ~clk;
  function automatic logic bitof(input logic [7:0] d, input int k);
`ifdef ONEBIT_MSB_FIRST_EN
    return d[7 - k];
`else
    return d[k];
`endif
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic cyc(input logic e, input logic s, input logic b, input logic v, input logic r, input logic c);
    en = e; sof = s; bit_in = b; bit_vld = v; word_rdy = r; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic e, s, v, b, r, c, ev, input logic [7:0] ew, input logic eb, input logic [3:0] ec, input logic eo);
    vec_t t;
    t.en = e; t.sof = s; t.vld = v; t.b = b; t.rdy = r; t.clr = c;
    t.ev = ev; t.ew = ew; t.eb = eb; t.ec = ec; t.eo = eo;
    tbl.push_back(t);
  endtask
  task automatic send(input string n, input logic [7:0] d, input logic s, input logic r, input logic c_last);
    for (int k = 0; k < 8; k++) begin
      cyc(1, s && k == 0, bitof(d, k), 1, r, k == 7 ? c_last : 1'b0);
      if (word_vld) pulses++;
      chk($sformatf("%s_cnt%0d", n, k), bit_cnt, (k + 1) % 8);
    end
  endtask
  initial begin
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 0;
    chk("rst_word", word_out, 0);
    chk("rst_vld", word_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_ovf", ovf, 0);
    for (int i = 0; i < 8; i++)
      add(1, i == 0, 1, bitof(8'h1E, i), 1, 0, i == 7, i == 7 ? 8'h1E : 8'h00, 1, 4'((i + 1) % 8), 0);
    add(1, 0, 0, 0, 1, 0, 0, 8'h1E, 1, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0, 8'h1E, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      add(1, 0, 1, i[0], 1, 0, 0, 8'h1E, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].sof, tbl[i].b, tbl[i].vld, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_vld", i), word_vld, tbl[i].ev);
      chk($sformatf("tbl%0d_word", i), word_out, tbl[i].ew);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_cnt", i), bit_cnt, tbl[i].ec);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].eo);
    end
    pulses = 0;
    cyc(1, 1, 1, 1, 1, 0);
    cyc(1, 0, 1, 1, 1, 0);
    cyc(1, 0, 1, 1, 1, 0);
    chk("realign_cnt3", bit_cnt, 3);
    send("realign", 8'hA5, 1, 1, 0);
    chk("realign_word", word_out, 8'hA5);
    chk("realign_pulses", pulses, 1);
    chk("realign_ovf", ovf, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("realign_drain", word_vld, 0);
    send("ovf_a", 8'h11, 1, 0, 0);
    chk("ovf_a_word", word_out, 8'h11);
    chk("ovf_a_vld", word_vld, 1);
    send("ovf_b", 8'h22, 0, 0, 1);
    chk("ovf_keep", word_out, 8'h11);
    chk("ovf_set_wins", ovf, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("ovf_clr", ovf, 0);
    chk("ovf_vld_held", word_vld, 1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("ovf_drain_vld", word_vld, 0);
    chk("ovf_drain_word", word_out, 8'h11);
    pulses = 0;
    for (int w = 1; w <= 3; w++) begin
      for (int k = 0; k < 8; k++) begin
        cyc(1, w == 1 && k == 0, bitof(8'(w), k), 1, 1, 0);
        if (word_vld) pulses++;
        chk($sformatf("stream%0d_vld%0d", w, k), word_vld, k == 7);
      end
      chk($sformatf("stream%0d_word", w), word_out, w);
    end
    chk("stream_pulses", pulses, 3);
    cyc(1, 0, 0, 0, 1, 0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1, k == 0, 1, 1, 1, 0);
      if (word_vld) pulses++;
    end
    cyc(0, 0, 1, 1, 1, 0);
    chk("en_low_busy", busy, 0);
    chk("en_low_cnt", bit_cnt, 0);
    send("ff", 8'hFF, 1, 0, 0);
    chk("ff_word", word_out, 8'hFF);
    chk("ff_vld", word_vld, 1);
    chk("ff_pulses", pulses, 1);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("mid_busy", busy, 1);
    chk("mid_cnt", bit_cnt, 2);
    rst = 1;
    cyc(1, 0, 1, 1, 0, 0);
    rst = 0;
    chk("rst2_word", word_out, 0);
    chk("rst2_vld", word_vld, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_cnt", bit_cnt, 0);
    chk("rst2_ovf", ovf, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onebit_parallel_ctrl.md
# onebit_parallel_ctrl

Frame-aligned controller for the one-bit-to-parallel datapath: samples a qualified serial bit stream, sequences bit capture with a frame-start marker and a bit counter, and hands each completed WIDTH-bit word to downstream logic over a valid/ready handshake. Sits between the serial line receiver and the parallel word consumer. It owns alignment, word completion and overflow reporting for the converter.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter and `bit_cnt`.
- clk  input  1  single clock; all logic samples on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enable; low forces IDLE and discards any partial word.
- sof  input  1  start of frame; qualified by `bit_vld`; marks the current bit as bit 0 of a new word.
- bit_in  input  1  serial data bit.
- bit_vld  input  1  `bit_in`/`sof` valid this cycle.
- word_out  output  WIDTH  assembled word; stable while `word_vld`=1.
- word_vld  output  1  `word_out` holds an untransferred word.
- word_rdy  input  1  consumer accepts; transfer when `word_vld`&&`word_rdy`.
- busy  output  1  state is SHIFT.
- bit_cnt  output  CNT_W  bits captured into the current partial word (0..WIDTH-1).
- ovf  output  1  sticky overflow flag.
- clr_ovf  input  1  clears `ovf`.

## Operation
- States: IDLE, SHIFT.
- IDLE: bits ignored. On `en`&&`bit_vld`&&`sof`: capture bit as bit 0, `bit_cnt`<=1, go to SHIFT.
- SHIFT, `bit_vld`&&!`sof`: capture bit at position `bit_cnt`, increment `bit_cnt`.
- SHIFT, `bit_vld`&&`sof`: discard partial word; this bit becomes bit 0, `bit_cnt`<=1 (re-alignment; no word emitted, `ovf` unaffected).
- Word completion: WIDTH-th bit captured -> assembled word offered to output register; `bit_cnt`<=0; stay in SHIFT, next `bit_vld` starts next word without requiring `sof`.
- Output register loads when `word_vld`=0 or `word_rdy`=1 in the completion cycle; otherwise the new word is dropped, `word_out` keeps the old word, `ovf`<=1.
- `en` low in any state: next cycle IDLE, `bit_cnt`=0, partial dropped; `word_vld`/`word_out` unaffected (pending word still drains).
- `ovf`: set by drop, cleared by `clr_ovf`; simultaneous set and clear -> set wins.
- Capture order: LSB first by default (first bit after `sof` -> `word_out[0]`); see Configuration.
- Bits with `bit_vld`=0 are never captured; gaps of any length allowed.

## Timing
- Reset values: state IDLE, `word_out`=0, `word_vld`=0, `busy`=0, `bit_cnt`=0, `ovf`=0; partial shift register cleared.
- Latency: `word_vld` rises the cycle after the WIDTH-th valid bit is sampled.
- `word_vld` falls the cycle after a transfer unless a new word loads in that same cycle (back-to-back, zero bubble).
- Minimum word period WIDTH cycles at `bit_vld`=1 continuous; sustained with `word_rdy`=1.
- `busy`, `bit_cnt` reflect registered state (update one cycle after the qualifying bit).
- `ovf` rises the cycle after the dropped completion.
- `rst` mid-word or with `word_vld`=1: all state returns to reset values next edge; pending word lost, no `ovf`.

## Configuration
- ONEBIT_MSB_FIRST_EN defined: first captured bit after `sof` lands in `word_out[WIDTH-1]`, bit k in `word_out[WIDTH-1-k]`.
- Undefined: LSB first, bit k in `word_out[k]`. No other behaviour changes.

## Test plan
- Reset then `en`=1, send 0,1,1,1,1,0,0,0 with `sof` on first bit, `word_rdy`=1 -> `word_out`=0x1E, `word_vld` high one cycle, 1 cycle after 8th bit; `bit_cnt` 1..7 then 0. With ONEBIT_MSB_FIRST_EN, bits 0,0,0,1,1,1,1,0 -> 0x1E.
- Bits without `sof` in IDLE (16 bits) -> `word_vld` never asserts, `busy`=0.
- 3 bits then `sof` with new 8-bit frame 0xA5 -> single word 0xA5, partial discarded, `ovf`=0.
- `word_rdy`=0, two consecutive words 0x11, 0x22 -> `word_out` stays 0x11, `ovf`=1 cycle after second completion; `clr_ovf` pulse -> `ovf`=0; `word_rdy`=1 -> 0x11 transferred.
- Continuous 3-word stream 0x01,0x02,0x03, `word_rdy`=1, no gaps -> three words, `word_vld` pulses every 8 cycles.
- `en` low after 5 bits, then high with `sof`+0xFF -> only 0xFF emitted; `rst` mid-word with `word_vld`=1 -> all outputs 0 next cycle.
